// File: rtl/mips_bp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mips_bp_pkg                                                     |
// | Brief    : Shared constants and helpers for the ID-stage branch predictor. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mips_bp_pkg;

    // Reset and threshold values for the default 2-bit counter.
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;

    // Weakly-not-taken for any counter width: MSB clear, all lower bits set.
    function automatic int cnt_wnt(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Weakly-taken for any counter width: only the MSB set.
    function automatic int cnt_wt(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    // Word-aligned PC to table index: PC[idx_w+1:2].
    function automatic logic [31:0] bht_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & 32'((1 << idx_w) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bht_table                                                       |
// | Brief    : Saturating-counter branch history table, async IF read port,    |
// |            sync read-modify-write training port, sync active-low reset.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bht_table
    import mips_bp_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 2,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam logic [CNT_W-1:0] c_wnt = CNT_W'(cnt_wnt(CNT_W));
    localparam logic [CNT_W-1:0] c_max = '1;
    localparam logic [CNT_W-1:0] c_min = '0;

    logic [CNT_W-1:0] r_cnt [BHT_DEPTH];
    logic [CNT_W-1:0] w_cur;
    logic [CNT_W-1:0] w_next;

    assign w_cur = r_cnt[i_wr_idx];

    always_comb begin
        w_next = w_cur;
        if (i_wr_taken) begin
            if (w_cur != c_max) w_next = w_cur + 1'b1;
        end else begin
            if (w_cur != c_min) w_next = w_cur - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_cnt[i] <= c_wnt;
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= w_next;
        end
    end

    // No write bypass: a same-cycle update shows up on the next fetch.
    assign o_rd_taken = r_cnt[i_rd_idx][CNT_W-1];

endmodule
`default_nettype wire

// File: rtl/id_branch_resolve_bht.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : id_branch_resolve_bht                                           |
// | Brief    : ID-stage BEQ/BNE resolution with BHT prediction, mispredict     |
// |            flagging and saturating branch/mispredict statistics.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module id_branch_resolve_bht
    import mips_bp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 2,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Branch_ID,
    input  logic              BranchNE_ID,
    input  logic [DATA_W-1:0] ReadData1_ID,
    input  logic [DATA_W-1:0] ReadData2_ID,
    input  logic [31:0]       PC_ID,
    input  logic              PredTaken_ID,
    input  logic              Stall_ID,
    input  logic [31:0]       PC_IF,
    output logic              PredTaken_IF,
    output logic              Zero_ID,
    output logic              PCSrc_ID,
    output logic              Mispredict_ID,
    output logic [STAT_W-1:0] BranchCnt,
    output logic [STAT_W-1:0] MispredCnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic              w_resolve;
    logic [IDX_W-1:0]  w_idx_id;
    logic [IDX_W-1:0]  w_idx_if;
    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_mispred_cnt;

    assign Zero_ID       = (ReadData1_ID == ReadData2_ID);
    assign PCSrc_ID      = Branch_ID & (BranchNE_ID ? ~Zero_ID : Zero_ID);
    // Reset gates resolution so a mid-run reset cycle trains nothing.
    assign w_resolve     = Branch_ID & ~Stall_ID & rst_n;
    assign Mispredict_ID = w_resolve & (PCSrc_ID != PredTaken_ID);

    assign w_idx_id = IDX_W'(bht_idx(PC_ID, IDX_W));
    assign w_idx_if = IDX_W'(bht_idx(PC_IF, IDX_W));

    bht_table #(
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (w_idx_if),
        .o_rd_taken (PredTaken_IF),
        .i_wr_en    (w_resolve),
        .i_wr_idx   (w_idx_id),
        .i_wr_taken (PCSrc_ID)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_resolve) begin
            if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (Mispredict_ID && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign BranchCnt  = r_branch_cnt;
    assign MispredCnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_branch_resolve_bht.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_id_branch_resolve_bht                                        |
// | Brief    : Directed scoreboard bench for id_branch_resolve_bht.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_id_branch_resolve_bht;

    localparam int c_sel_pif = 0;
    localparam int c_sel_zero = 1;
    localparam int c_sel_pcsrc = 2;
    localparam int c_sel_mis = 3;
    localparam int c_sel_bc = 4;
    localparam int c_sel_mc = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Branch_ID, BranchNE_ID, PredTaken_ID, Stall_ID;
    logic [31:0] ReadData1_ID, ReadData2_ID, PC_ID, PC_IF;
    logic        PredTaken_IF, Zero_ID, PCSrc_ID, Mispredict_ID;
    logic [15:0] BranchCnt, MispredCnt;

    int          checks = 0;
    int          errors = 0;
    int          q_sel [$];
    logic [31:0] q_val [$];
    string       q_name [$];

    int          m_sel;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;

    id_branch_resolve_bht dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Branch_ID     (Branch_ID),
        .BranchNE_ID   (BranchNE_ID),
        .ReadData1_ID  (ReadData1_ID),
        .ReadData2_ID  (ReadData2_ID),
        .PC_ID         (PC_ID),
        .PredTaken_ID  (PredTaken_ID),
        .Stall_ID      (Stall_ID),
        .PC_IF         (PC_IF),
        .PredTaken_IF  (PredTaken_IF),
        .Zero_ID       (Zero_ID),
        .PCSrc_ID      (PCSrc_ID),
        .Mispredict_ID (Mispredict_ID),
        .BranchCnt     (BranchCnt),
        .MispredCnt    (MispredCnt)
    );

    always #5 clk = ~clk;

    // Monitor: drains every expectation queued for this cycle at the falling edge.
    always @(negedge clk) begin
        while (q_sel.size() > 0) begin
            m_sel  = q_sel.pop_front();
            m_exp  = q_val.pop_front();
            m_name = q_name.pop_front();
            case (m_sel)
                c_sel_pif:   m_act = {31'd0, PredTaken_IF};
                c_sel_zero:  m_act = {31'd0, Zero_ID};
                c_sel_pcsrc: m_act = {31'd0, PCSrc_ID};
                c_sel_mis:   m_act = {31'd0, Mispredict_ID};
                c_sel_bc:    m_act = {16'd0, BranchCnt};
                default:     m_act = {16'd0, MispredCnt};
            endcase
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", m_name, m_act, m_exp);
            end
        end
    end

    task automatic push(input int sel, input logic [31:0] v, input string nm);
        q_sel.push_back(sel);
        q_val.push_back(v);
        q_name.push_back(nm);
    endtask

    task automatic exp_br(input string tag, input logic zero, input logic pcsrc,
                          input logic mis, input logic pif);
        push(c_sel_zero,  {31'd0, zero},  {tag, ".Zero_ID"});
        push(c_sel_pcsrc, {31'd0, pcsrc}, {tag, ".PCSrc_ID"});
        push(c_sel_mis,   {31'd0, mis},   {tag, ".Mispredict_ID"});
        push(c_sel_pif,   {31'd0, pif},   {tag, ".PredTaken_IF"});
    endtask

    task automatic exp_state(input string tag, input logic pif,
                             input logic [15:0] bc, input logic [15:0] mc);
        push(c_sel_pif, {31'd0, pif}, {tag, ".PredTaken_IF"});
        push(c_sel_bc,  {16'd0, bc},  {tag, ".BranchCnt"});
        push(c_sel_mc,  {16'd0, mc},  {tag, ".MispredCnt"});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic br, input logic ne, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pcid,
                          input logic pred, input logic stall, input logic [31:0] pcif);
        Branch_ID    = br;
        BranchNE_ID  = ne;
        ReadData1_ID = a;
        ReadData2_ID = b;
        PC_ID        = pcid;
        PredTaken_ID = pred;
        Stall_ID     = stall;
        PC_IF        = pcif;
    endtask

    task automatic idle(input logic [31:0] pcif);
        set_in(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, pcif);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(32'h40);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_state("reset", 1'b0, 16'd0, 16'd0);

        // Taken BEQ against a weakly-not-taken entry.
        cycle();
        set_in(1'b1, 1'b0, 32'h1234, 32'h1234, 32'h40, 1'b0, 1'b0, 32'h40);
        exp_br("beq_first", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        idle(32'h40);
        exp_state("beq_first_after", 1'b1, 16'd1, 16'd1);
        push(c_sel_mis, 32'd0, "idle.Mispredict_ID");

        // Not-taken BNE x3 must floor at zero; a taken step then lands on 01.
        for (int i = 0; i < 3; i++) begin
            cycle();
            set_in(1'b1, 1'b1, 32'd5, 32'd5, 32'h44, 1'b0, 1'b0, 32'h44);
            exp_br("bne_nt", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cycle();
        set_in(1'b1, 1'b0, 32'd5, 32'd5, 32'h44, 1'b0, 1'b0, 32'h44);
        exp_br("floor_taken", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        idle(32'h44);
        exp_state("floor_after", 1'b0, 16'd5, 16'd2);

        // Taken BEQ x4: 01->10->11->11->11.
        for (int i = 0; i < 4; i++) begin
            cycle();
            set_in(1'b1, 1'b0, 32'd7, 32'd7, 32'h48, (i != 0), 1'b0, 32'h48);
            exp_br("beq_sat", 1'b1, 1'b1, (i == 0), (i != 0));
        end
        cycle();
        idle(32'h48);
        exp_state("beq_sat_after", 1'b1, 16'd9, 16'd3);

        cycle();
        set_in(1'b1, 1'b1, 32'd1, 32'd2, 32'h48, 1'b1, 1'b0, 32'h48);
        exp_br("bne_taken", 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        set_in(1'b1, 1'b1, 32'd9, 32'd9, 32'h48, 1'b1, 1'b0, 32'h48);
        exp_br("bne_nt_hi", 1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        set_in(1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'h48, 1'b1, 1'b0, 32'h48);
        exp_br("beq_msb_diff", 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        idle(32'h48);
        exp_state("decay_after", 1'b0, 16'd12, 16'd5);

        // Stalled branch resolves combinationally but trains nothing.
        cycle();
        set_in(1'b1, 1'b0, 32'd3, 32'd3, 32'h4C, 1'b0, 1'b1, 32'h4C);
        exp_br("stall", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        idle(32'h4C);
        exp_state("stall_after", 1'b0, 16'd12, 16'd5);

        // Drive BranchCnt up to 0xFFFE with correctly predicted taken branches.
        for (int i = 0; i < 16'hFFFE - 12; i++) begin
            cycle();
            set_in(1'b1, 1'b0, 32'd1, 32'd1, 32'h50, 1'b1, 1'b0, 32'h50);
        end
        cycle();
        idle(32'h50);
        exp_state("bulk_after", 1'b1, 16'hFFFE, 16'd5);

        for (int i = 0; i < 2; i++) begin
            cycle();
            set_in(1'b1, 1'b0, 32'd1, 32'd1, 32'h50, 1'b0, 1'b0, 32'h50);
            push(c_sel_mis, 32'd1, "sat.Mispredict_ID");
            cycle();
            idle(32'h50);
            exp_state("sat_after", 1'b1, 16'hFFFF, 16'(6 + i));
        end

        // Reset while a branch is in ID.
        cycle();
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 32'd1, 32'd1, 32'h50, 1'b0, 1'b0, 32'h50);
        push(c_sel_pcsrc, 32'd1, "rst_mid.PCSrc_ID");
        push(c_sel_mis,   32'd0, "rst_mid.Mispredict_ID");
        cycle();
        rst_n = 1'b1;
        idle(32'h50);
        exp_state("rst_after", 1'b0, 16'd0, 16'd0);

        // 0x90 aliases 0x50 (index 4): one taken step from 01 shows through it.
        cycle();
        set_in(1'b1, 1'b0, 32'd1, 32'd1, 32'h50, 1'b0, 1'b0, 32'h50);
        exp_br("post_rst", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        idle(32'h90);
        exp_state("alias", 1'b1, 16'd1, 16'd1);

        cycle();
        idle(32'h48);
        push(c_sel_pif, 32'd0, "rst_entry2.PredTaken_IF");

        repeat (2) @(posedge clk);
        #1;
        if (q_sel.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q_sel.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
